uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares the single 8N1 UART transmitter (65 MHz, 9600 baud) between N_REQ byte producers: paddle commands, score events, game-state reports.
- Arbitrates round-robin and hands one byte at a time to the transmitter over a valid/ready handshake.
- Waits for that frame's completion, then enforces a minimum inter-byte idle gap.
- Recovers from a transmitter that never reports completion by timing out and flagging an error.

Parameters:
N_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 6770, idle clocks inserted after each completed frame; 0 disables the gap (one bit time at 65 MHz / 9600)
TIMEOUT_CYCLES, 70000, max clocks to wait for tx_done after handoff; must exceed one 10-bit frame (67700)

Ports:
clk  in  1  system clock, 65 MHz
rst  in  1  reset, asynchronous, active-low
req_valid  in  N_REQ  requester i has a byte pending; must hold valid and data stable until accepted
req_data  in  N_REQ*8  byte of requester i in bits [8i+7:8i]
req_ready  out  N_REQ  one-hot, one-cycle accept pulse to the granted requester
tx_valid  out  1  byte offered to the transmitter
tx_data  out  8  byte offered to the transmitter
tx_ready  in  1  transmitter idle; a transfer occurs when tx_valid and tx_ready are both high
tx_done  in  1  one-cycle pulse when the stop bit has finished
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(N_REQ)  index of the current or last granted requester
err_timeout  out  1  one-cycle pulse when the WAIT_DONE timeout fires

Behaviour:
- Reset (rst low, asynchronous) values:
  - state=IDLE, rr_ptr=0, all counters 0
  - req_ready=0, tx_valid=0, tx_data=0x00, busy=0, grant_id=0, err_timeout=0
- Outputs are registered.
- Arbitration: round-robin starting at rr_ptr, searching rr_ptr, rr_ptr+1, … modulo N_REQ. The first index with req_valid high wins.
- rr_ptr update: set to (winner+1) mod N_REQ only on acceptance. Wraps from N_REQ-1 to 0.
- IDLE: if any req_valid is high in cycle t, register the winner g, set grant_id=g and go to GRANT.
- GRANT (cycle t+1): req_ready[g]=1 for exactly this cycle.
  - If req_valid[g] is high: latch req_data[g] into tx_data, update rr_ptr, go to OFFER.
  - If req_valid[g] is low (protocol violation): return to IDLE. rr_ptr is unchanged and nothing is latched.
- OFFER: tx_valid=1 from cycle t+2 and held until a cycle where tx_ready=1.
  - On that transfer: tx_valid=0 next cycle, clear the timeout counter, go to WAIT_DONE.
  - tx_data stays stable throughout OFFER.
- WAIT_DONE: the timeout counter increments each cycle.
  - On tx_done: go to GAP (or IDLE if GAP_CYCLES=0).
  - If the counter reaches TIMEOUT_CYCLES-1 with no tx_done: pulse err_timeout for one cycle and go to IDLE without a gap.
  - If tx_done and timeout coincide, tx_done wins and err_timeout is not raised.
- GAP: count GAP_CYCLES clocks, then go to IDLE. New requests are not sampled during GAP.
- Timing with GAP_CYCLES=0 and tx_ready high: the next grant is registered one cycle after tx_done; a back-to-back byte reaches tx_valid 3 cycles after tx_done.
- Stray inputs: tx_done outside WAIT_DONE is ignored. tx_ready outside OFFER is ignored.
- Reset mid-operation (any state) returns to IDLE immediately. tx_valid drops asynchronously and the latched byte is discarded.
- Counter widths are $clog2(param+1). With GAP_CYCLES=0 the gap counter is unused but still synthesizable.

Decomposition:
- Shared package pong_uart_pkg holds:
  - byte_t (logic [7:0])
  - constants CLK_FREQ=65_000_000, BAUD_RATE=9_600, BIT_CYCLES=CLK_FREQ/BAUD_RATE
  - command codes CMD_UP=0x41 ('A'), CMD_DOWN=0x42 ('B')
  - state enum sched_state_t {IDLE, GRANT, OFFER, WAIT_DONE, GAP}
- One sub-module, rr_arbiter: combinational priority search from rr_ptr. Inputs are the valid vector and rr_ptr; outputs are any_valid and winner index.

Test Plan:
- Requester 2 only, req_data=0x41, tx_ready=1, tx_done pulsed 67700 cycles after transfer.
  -> req_ready=0b0100 at t+1; tx_valid=1 with tx_data=0x41 at t+2; busy high until GAP_CYCLES clocks after tx_done.
- All 4 requesters valid continuously, each with distinct bytes, GAP_CYCLES=0, transmitter model auto-completing.
  -> grant order 0,1,2,3,0 and tx_data sequence matches; no requester is granted twice in a row.
- tx_ready held low for 50 cycles during OFFER.
  -> tx_valid stays high and tx_data stays stable for 50 cycles; transfer occurs on the first tx_ready high.
- tx_done never arrives, TIMEOUT_CYCLES=1000.
  -> err_timeout pulses once, 1000 cycles after transfer; state=IDLE; a pending request is granted the next cycle.
- Requester 1 drops req_valid during GRANT.
  -> no transfer; rr_ptr unchanged; requester 1 is granted first when it reasserts.
- rst low during WAIT_DONE.
  -> tx_valid=0, busy=0, req_ready=0, grant_id=0 immediately; after release, requester 0 is granted first.

Source files
------------

// File: rtl/pong_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_uart_pkg
// Description : Shared types and constants for the pong UART transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_uart_pkg;

   typedef logic [7:0] byte_t;

   localparam int unsigned CLK_FREQ   = 65_000_000;
   localparam int unsigned BAUD_RATE  = 9_600;
   localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD_RATE;

   localparam byte_t CMD_UP   = 8'h41;
   localparam byte_t CMD_DOWN = 8'h42;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      GRANT     = 3'd1,
      OFFER     = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search starting at rr_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             any_valid,
   output logic [IDX_W-1:0] winner
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;

   // Scan from the farthest offset down so the nearest valid index to rr_ptr wins
   always_comb begin
      any_valid = |valid;
      winner    = '0;
      sum       = '0;
      idx       = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
         end
         idx = sum[IDX_W-1:0];
         if (valid[idx]) begin
            winner = idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Round-robin sharing of one UART transmitter between N_REQ
//               byte producers, with inter-byte gap and completion timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
   import pong_uart_pkg::*;
#(
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned GAP_CYCLES     = 6770,
   parameter int unsigned TIMEOUT_CYCLES = 70000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*8-1:0]         req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       tx_valid,
   output logic [7:0]                 tx_data,
   input  logic                       tx_ready,
   input  logic                       tx_done,
   output logic                       busy,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       err_timeout
);

   localparam int unsigned IDX_W = $clog2(N_REQ);
   // A zero gap still needs a legal one-bit counter
   localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   sched_state_t     state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] grant_id_q, grant_id_d;
   logic [N_REQ-1:0] req_ready_q, req_ready_d;
   logic             tx_valid_q, tx_valid_d;
   byte_t            tx_data_q, tx_data_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

   logic             any_valid;
   logic [IDX_W-1:0] winner;
   byte_t            req_bytes [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_split
      assign req_bytes[gi] = req_data[gi*8 +: 8];
   end

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .valid     (req_valid),
      .rr_ptr    (rr_ptr_q),
      .any_valid (any_valid),
      .winner    (winner)
   );

   // Next-state and next-output computation for the scheduler FSM
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      req_ready_d = '0;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = tx_data_q;
      err_d       = 1'b0;
      to_cnt_d    = to_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               grant_id_d          = winner;
               req_ready_d[winner] = 1'b1;
               state_d             = GRANT;
            end
         end
         GRANT: begin
            // A requester that withdrew during its grant forfeits it without moving the pointer
            if (req_valid[grant_id_q]) begin
               tx_data_d  = req_bytes[grant_id_q];
               rr_ptr_d   = (grant_id_q == IDX_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
               tx_valid_d = 1'b1;
               state_d    = OFFER;
            end else begin
               state_d = IDLE;
            end
         end
         OFFER: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               to_cnt_d   = '0;
               state_d    = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            // Completion takes priority over a timeout in the same cycle
            if (tx_done) begin
               if (GAP_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  gap_cnt_d = '0;
                  state_d   = GAP;
               end
            end else if (to_cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         req_ready_q <= '0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         to_cnt_q    <= '0;
         gap_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_id_q  <= grant_id_d;
         req_ready_q <= req_ready_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         to_cnt_q    <= to_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign tx_valid    = tx_valid_q;
   assign tx_data     = tx_data_q;
   assign busy        = busy_q;
   assign grant_id    = grant_id_q;
   assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Directed self-checking bench for uart_tx_scheduler.
//               dut_a uses the default gap/timeout, dut_b uses GAP_CYCLES=0
//               and TIMEOUT_CYCLES=1000. Both share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic        tx_ready = 1'b0;
   logic        tx_done_man = 1'b0;
   logic        tx_done_auto = 1'b0;
   logic        tx_done;

   logic [3:0] req_ready_a, req_ready_b;
   logic       tx_valid_a, tx_valid_b;
   logic [7:0] tx_data_a, tx_data_b;
   logic       busy_a, busy_b;
   logic [1:0] grant_id_a, grant_id_b;
   logic       err_a, err_b;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   done_cyc = 0;
   bit   have_done = 0;
   bit   prev_valid = 0;
   bit   auto_tx = 0;
   bit   mon_b = 0;
   bit   watch_a = 0;
   bit   err_a_seen = 0;
   int   n;
   int   stable;
   exp_t sb[$];

   assign tx_done = tx_done_man | tx_done_auto;

   uart_tx_scheduler #(.N_REQ(4), .GAP_CYCLES(6770), .TIMEOUT_CYCLES(70000)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready_a), .tx_valid(tx_valid_a), .tx_data(tx_data_a),
      .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy_a),
      .grant_id(grant_id_a), .err_timeout(err_a)
   );

   uart_tx_scheduler #(.N_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(1000)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready_b), .tx_valid(tx_valid_b), .tx_data(tx_data_b),
      .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy_b),
      .grant_id(grant_id_b), .err_timeout(err_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      tx_ready  = 1'b0;
      rst       = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   // Scoreboard: every dut_b transfer must match the oldest expected grant/byte
   always @(negedge clk) begin
      if (mon_b && rst && tx_valid_b && tx_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_transfer", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_grant_id", {30'd0, grant_id_b}, {30'd0, e.id});
            check("sb_tx_data", {24'd0, tx_data_b}, {24'd0, e.data});
         end
      end
   end

   // Back-to-back latency: next tx_valid rises 3 cycles after tx_done (gap disabled)
   always @(negedge clk) begin
      if (auto_tx) begin
         if (tx_done) begin
            done_cyc  = cyc;
            have_done = 1;
         end
         if (tx_valid_b && !prev_valid && have_done) begin
            check("b2b_latency", cyc - done_cyc, 32'd3);
         end
         prev_valid = tx_valid_b;
      end
      if (watch_a && err_a) err_a_seen = 1;
   end

   // Auto-completing transmitter model: done pulse 5 cycles after each transfer
   always begin
      @(negedge clk);
      if (auto_tx && tx_valid_b && tx_ready) begin
         repeat (5) @(posedge clk);
         #1 tx_done_auto = 1'b1;
         @(posedge clk);
         #1 tx_done_auto = 1'b0;
      end
   end

   initial begin
      // ---------------- reset values ----------------
      tick();
      check("rst_tx_valid", {31'd0, tx_valid_b}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data_b}, 32'd0);
      check("rst_req_ready", {28'd0, req_ready_b}, 32'd0);
      check("rst_busy", {31'd0, busy_b}, 32'd0);
      check("rst_grant_id", {30'd0, grant_id_b}, 32'd0);
      check("rst_err", {31'd0, err_a}, 32'd0);
      rst = 1'b1;
      tick();

      // ---------------- single requester 2, full gap (dut_a) ----------------
      watch_a   = 1;
      req_valid = 4'b0100;
      req_data  = 32'h0041_0000;
      tx_ready  = 1'b1;
      tick();
      check("t1_req_ready", {28'd0, req_ready_a}, 32'b0100);
      check("t1_grant_id", {30'd0, grant_id_a}, 32'd2);
      check("t1_busy_grant", {31'd0, busy_a}, 32'd1);
      tick();
      req_valid = '0;
      check("t1_tx_valid", {31'd0, tx_valid_a}, 32'd1);
      check("t1_tx_data", {24'd0, tx_data_a}, 32'h41);
      check("t1_req_ready_off", {28'd0, req_ready_a}, 32'd0);
      tick();
      check("t1_tx_valid_drop", {31'd0, tx_valid_a}, 32'd0);
      repeat (67699) tick();
      check("t1_busy_wait", {31'd0, busy_a}, 32'd1);
      tx_done_man = 1'b1;
      tick();
      tx_done_man = 1'b0;
      repeat (6769) tick();
      check("t1_busy_gap_end", {31'd0, busy_a}, 32'd1);
      tick();
      check("t1_busy_idle", {31'd0, busy_a}, 32'd0);
      watch_a = 0;
      check("t1_no_err", {31'd0, err_a_seen}, 32'd0);

      // ---------------- all four valid, gap disabled (dut_b) ----------------
      do_reset();
      mon_b     = 1;
      have_done = 0;
      prev_valid = 0;
      auto_tx   = 1;
      sb.push_back('{2'd0, 8'h10});
      sb.push_back('{2'd1, 8'h21});
      sb.push_back('{2'd2, 8'h32});
      sb.push_back('{2'd3, 8'h43});
      sb.push_back('{2'd0, 8'h10});
      req_data  = 32'h4332_2110;
      tx_ready  = 1'b1;
      req_valid = 4'b1111;
      n = 0;
      while (sb.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      req_valid = '0;
      check("t2_sb_drained", sb.size(), 32'd0);
      repeat (12) tick();
      auto_tx = 0;

      // ---------------- tx_ready stalled 50 cycles ----------------
      do_reset();
      req_valid = 4'b0001;
      req_data  = 32'h0000_005A;
      tick();
      tick();
      req_valid = '0;
      stable = 0;
      for (int i = 0; i < 50; i++) begin
         if (tx_valid_b === 1'b1 && tx_data_b === 8'h5A) stable++;
         tick();
      end
      check("t3_stable_cycles", stable, 32'd50);
      sb.push_back('{2'd0, 8'h5A});
      tx_ready = 1'b1;
      tick();
      check("t3_tx_valid_drop", {31'd0, tx_valid_b}, 32'd0);

      // ---------------- no tx_done: timeout, pending requester 1 ----------------
      req_valid = 4'b0010;
      req_data  = 32'h0000_7700;
      sb.push_back('{2'd1, 8'h77});
      n = 0;
      while (err_b !== 1'b1 && n < 1100) begin
         tick();
         n++;
      end
      check("t4_timeout_cycles", n, 32'd1000);
      check("t4_idle_on_err", {31'd0, busy_b}, 32'd0);
      tick();
      check("t4_err_one_pulse", {31'd0, err_b}, 32'd0);
      check("t4_regrant_ready", {28'd0, req_ready_b}, 32'b0010);
      check("t4_regrant_id", {30'd0, grant_id_b}, 32'd1);
      tick();
      req_valid = '0;
      tick();
      tick();
      tx_done_man = 1'b1;
      tick();
      tx_done_man = 1'b0;
      tick();
      // stray tx_done while idle must not wake the scheduler
      tx_done_man = 1'b1;
      tick();
      tx_done_man = 1'b0;
      check("t4_stray_done", {31'd0, busy_b}, 32'd0);

      // ---------------- requester 1 withdraws during GRANT ----------------
      do_reset();
      tx_ready  = 1'b1;
      req_data  = 32'h4332_2110;
      req_valid = 4'b0010;
      tick();
      check("t5_first_ready", {28'd0, req_ready_b}, 32'b0010);
      req_valid = '0;
      tick();
      check("t5_back_idle", {31'd0, busy_b}, 32'd0);
      check("t5_no_offer", {31'd0, tx_valid_b}, 32'd0);
      req_valid = 4'b1110;
      tick();
      check("t5_regrant_id", {30'd0, grant_id_b}, 32'd1);
      check("t5_regrant_ready", {28'd0, req_ready_b}, 32'b0010);
      sb.push_back('{2'd1, 8'h21});
      tick();
      req_valid = '0;
      tick();
      tick();
      tx_done_man = 1'b1;
      tick();
      tx_done_man = 1'b0;
      tick();

      // ---------------- reset during WAIT_DONE ----------------
      req_valid = 4'b0100;
      sb.push_back('{2'd2, 8'h32});
      tick();
      tick();
      req_valid = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("t6_tx_valid", {31'd0, tx_valid_b}, 32'd0);
      check("t6_tx_data", {24'd0, tx_data_b}, 32'd0);
      check("t6_busy", {31'd0, busy_b}, 32'd0);
      check("t6_req_ready", {28'd0, req_ready_b}, 32'd0);
      check("t6_grant_id", {30'd0, grant_id_b}, 32'd0);
      tick();
      rst = 1'b1;
      req_valid = 4'b1001;
      sb.push_back('{2'd0, 8'h10});
      tick();
      check("t6_first_id", {30'd0, grant_id_b}, 32'd0);
      check("t6_first_ready", {28'd0, req_ready_b}, 32'b0001);
      tick();
      req_valid = '0;
      tick();
      tick();
      tx_done_man = 1'b1;
      tick();
      tx_done_man = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      check("final_sb_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
